rca_wide_seq: RTL and testbench

- Multi-cycle sequencer that performs a WORDS×32-bit addition on a single shared rca_32bit instance, one 32-bit chunk per cycle, LSB chunk first.
- The carry out of each chunk is registered and fed back as the carry in of the next chunk.
- Sits between a valid/ready producer and a valid/ready consumer.
- Trades latency for area when wide sums are needed but only one 32-bit adder is affordable.

---
 rtl/rca_pkg.sv | 12 +
 rtl/rca_32bit.sv | 21 ++
 rtl/rca_wide_seq.sv | 124 ++++++++++++
 tb/tb_rca_wide_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the wide ripple-carry sequencer: chunk width and FSM state encoding.
package rca_pkg;

  localparam int RCA_CHUNK_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rca_seq_state_t;

endpackage

// File: rtl/rca_32bit.sv
// Combinational 32-bit ripple-carry adder; the single shared chunk adder of rca_wide_seq.
module rca_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  always_comb begin
    logic carry;
    sum   = '0;
    carry = c_in;
    for (int i = 0; i < 32; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c_out = carry;
  end

endmodule

// File: rtl/rca_wide_seq.sv
// WORDS x 32-bit adder built from one rca_32bit, one chunk per cycle, LSB chunk first.
// Optional subtract mode (a - b, c_out = no borrow) enabled by defining RCA_WIDE_SEQ_SUB_EN.
module rca_wide_seq
  import rca_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [RCA_CHUNK_W*WORDS-1:0] a,
  input  logic [RCA_CHUNK_W*WORDS-1:0] b,
  input  logic                         c_in,
`ifdef RCA_WIDE_SEQ_SUB_EN
  input  logic                         sub,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RCA_CHUNK_W*WORDS-1:0] sum,
  output logic                         c_out,
  output logic                         busy
);

  localparam int N     = RCA_CHUNK_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  rca_seq_state_t   state;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic             carry_q;
  logic [N-1:0]     sum_q;
  logic             c_out_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [RCA_CHUNK_W-1:0] chunk_sum;
  logic                   chunk_cout;
  logic [N+RCA_CHUNK_W-1:0] sum_cat;
  logic                   sub_sel;

`ifdef RCA_WIDE_SEQ_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  rca_32bit u_chunk_add (
    .a     (a_q[RCA_CHUNK_W-1:0]),
    .b     (b_q[RCA_CHUNK_W-1:0]),
    .c_in  (carry_q),
    .sum   (chunk_sum),
    .c_out (chunk_cout)
  );

  // New chunk enters at the top; after WORDS shifts chunk 0 sits at the bottom.
  assign sum_cat = {chunk_sum, sum_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            // Subtraction is a + ~b + 1, so the inverted operand and forced carry go in here.
            b_q        <= sub_sel ? ~b : b;
            carry_q    <= sub_sel ? 1'b1 : c_in;
            idx        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          a_q     <= a_q >> RCA_CHUNK_W;
          b_q     <= b_q >> RCA_CHUNK_W;
          sum_q   <= sum_cat[N+RCA_CHUNK_W-1:RCA_CHUNK_W];
          carry_q <= chunk_cout;
          idx     <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            state       <= DONE;
            c_out_q     <= chunk_cout;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rca_wide_seq.sv
// Self-checking bench for rca_wide_seq (WORDS=4): directed table, handshake corner sequences, random vs. model.
module tb_rca_wide_seq;

  localparam int WORDS = 4;
  localparam int N     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         c_out;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  rca_wide_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef RCA_WIDE_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] esum;
    logic         ecout;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [N:0] act, input logic [N:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, subtraction as two's complement.
  function automatic logic [N:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                       input logic mc, input logic ms);
    if (ms) return {1'b0, ma} - {1'b0, mb} + {1'b1, {N{1'b0}}};
    return {1'b0, ma} + {1'b0, mb} + {{N{1'b0}}, mc};
  endfunction

  // Issue one operation with out_ready held high; report result, latency and busy cycles.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc,
                        input logic ts, output logic [N-1:0] rs, output logic rc,
                        output int lat, output int bcnt);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    if (!in_ready) chk("in_ready_wait", {{N{1'b0}}, in_ready}, {{N{1'b0}}, 1'b1});
    a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = -1; bcnt = 0; rs = '0; rc = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (busy) bcnt++;
      if (out_valid) begin
        lat = k;
        rs  = sum;
        rc  = c_out;
        break;
      end
      step();
    end
    step();
  endtask

  vec_t         vecs[7];
  logic [N-1:0] rs, s_tmp;
  logic         rc;
  logic [N:0]   exp_full;
  int           lat, bcnt;
  int           t1, t2, nres;
  logic [N-1:0] res[2];
  logic         pre_rdy, pre_ov;

  initial begin
    vecs[0] = '{128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0,
                128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0};
    vecs[1] = '{{N{1'b1}}, 128'h0, 1'b1, 128'h0, 1'b1};
    vecs[2] = '{128'h1, 128'h2, 1'b0, 128'h3, 1'b0};
    vecs[3] = '{128'h0, 128'h0, 1'b1, 128'h1, 1'b0};
    vecs[4] = '{{N{1'b1}}, {N{1'b1}}, 1'b1, {N{1'b1}}, 1'b1};
    vecs[5] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000,
                128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 128'h0, 1'b1};
    vecs[6] = '{128'hFFFF_FFFF, 128'hFFFF_FFFF, 1'b1, 128'h1_FFFF_FFFF, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready",  {{N{1'b0}}, in_ready},  {{N{1'b0}}, 1'b1});
    chk("rst_out_valid", {{N{1'b0}}, out_valid}, '0);
    chk("rst_sum",       {1'b0, sum},            '0);
    chk("rst_c_out",     {{N{1'b0}}, c_out},     '0);
    chk("rst_busy",      {{N{1'b0}}, busy},      '0);
    rst = 1'b0;
    step();

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, rs, rc, lat, bcnt);
      chk($sformatf("tbl%0d_sum", i), {1'b0, rs}, {1'b0, vecs[i].esum});
      chk($sformatf("tbl%0d_c_out", i), {{N{1'b0}}, rc}, {{N{1'b0}}, vecs[i].ecout});
      chk($sformatf("tbl%0d_latency", i), N'(lat), N'(WORDS));
      chk($sformatf("tbl%0d_busy_cycles", i), N'(bcnt), N'(WORDS + 1));
    end

    // Backpressure: hold out_ready low for 3 cycles of out_valid
    out_ready = 1'b0;
    a = 128'h1; b = 128'h2; c_in = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_out_valid_%0d", k), {{N{1'b0}}, out_valid}, {{N{1'b0}}, 1'b1});
      chk($sformatf("bp_sum_%0d", k), {1'b0, sum}, {1'b0, 128'h3});
      chk($sformatf("bp_in_ready_%0d", k), {{N{1'b0}}, in_ready}, '0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_idle_in_ready",  {{N{1'b0}}, in_ready},  {{N{1'b0}}, 1'b1});
    chk("bp_idle_out_valid", {{N{1'b0}}, out_valid}, '0);
    chk("bp_sum_retained",   {1'b0, sum},            {1'b0, 128'h3});

    // Reset two cycles after accept
    a = 128'h55; b = 128'h66; c_in = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready",  {{N{1'b0}}, in_ready},  {{N{1'b0}}, 1'b1});
    chk("midrst_out_valid", {{N{1'b0}}, out_valid}, '0);
    chk("midrst_sum",       {1'b0, sum},            '0);
    chk("midrst_c_out",     {{N{1'b0}}, c_out},     '0);
    pre_ov = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) pre_ov = 1'b1;
      step();
    end
    chk("midrst_no_output", {{N{1'b0}}, pre_ov}, '0);

    // Back-to-back with in_valid held high
    t1 = -1; t2 = -1; nres = 0;
    a = 128'h1; b = 128'h1; c_in = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 40 && nres < 2; k++) begin
      pre_rdy = in_ready;
      pre_ov  = out_valid;
      s_tmp   = sum;
      step();
      if (pre_rdy) begin
        if (t1 < 0) begin
          t1 = cyc; a = 128'h7; b = 128'h8;
        end else begin
          t2 = cyc; in_valid = 1'b0;
        end
      end
      if (pre_ov) begin
        res[nres] = s_tmp;
        nres++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count",   N'(nres), N'(2));
    chk("b2b_first",   {1'b0, res[0]}, {1'b0, 128'd2});
    chk("b2b_second",  {1'b0, res[1]}, {1'b0, 128'd15});
    chk("b2b_spacing", N'(t2 - t1), N'(WORDS + 2));

`ifdef RCA_WIDE_SEQ_SUB_EN
    run_op(128'd5, 128'd7, 1'b0, 1'b1, rs, rc, lat, bcnt);
    chk("sub_5m7_sum",   {1'b0, rs}, {1'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE});
    chk("sub_5m7_c_out", {{N{1'b0}}, rc}, '0);
    run_op(128'd7, 128'd5, 1'b0, 1'b1, rs, rc, lat, bcnt);
    chk("sub_7m5_sum",   {1'b0, rs}, {1'b0, 128'd2});
    chk("sub_7m5_c_out", {{N{1'b0}}, rc}, {{N{1'b0}}, 1'b1});
`endif

    // Random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] ra, rb;
      logic         rcin, rsub;
      ra   = {$urandom, $urandom, $urandom, $urandom};
      rb   = {$urandom, $urandom, $urandom, $urandom};
      if (i % 5 == 0) ra = ~rb;
      rcin = 1'($urandom_range(0, 1));
      rsub = 1'b0;
`ifdef RCA_WIDE_SEQ_SUB_EN
      rsub = 1'($urandom_range(0, 1));
`endif
      exp_full = model(ra, rb, rcin, rsub);
      run_op(ra, rb, rcin, rsub, rs, rc, lat, bcnt);
      chk($sformatf("rand%0d_result", i), {rc, rs}, exp_full);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
